lcd_bus_responder: RTL and testbench
====================================

Name: lcd_bus_responder

Overview:
Synthesizable HD44780-compatible responder for the 4-bit LCD bus (db4..db7, rs, enable) driven by the team's character-LCD controller. It decodes strobes into bytes, executes the command subset the controller uses, and holds a 2-line DDRAM image readable by the bench or an on-chip checker. It is used as the loopback target for controller regression and as a hardware bus monitor on the FPGA.

Parameters:
MIN_EN_HIGH, 4, minimum enable-high width in clk cycles for a strobe to be accepted
LINE_LEN, 40, characters per line (line 0 at 0x00.., line 1 at 0x40..)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
db4, db5, db6, db7  in  1 each  LCD data nibble bits 0..3
rs  in  1  register select (0 command, 1 data)
enable  in  1  LCD strobe; data latched on falling edge
rdAddr  in  7  DDRAM read address
rdData  out  8  DDRAM read data
byteValid  out  1  one-cycle pulse per assembled byte
byteOut  out  8  assembled byte, valid with byteValid
byteIsData  out  1  rs of assembled byte, valid with byteValid
cursorAddr  out  7  current DDRAM address counter
fourBitMode  out  1  interface in 4-bit mode
twoLine  out  1  function-set N bit
displayOn  out  1  display-control D bit
entryIncrement  out  1  entry-mode I/D bit
busy  out  1  DDRAM clear in progress
errFlags  out  4  sticky: [0] short pulse, [1] rs mismatch, [2] bad address, [3] strobe while busy
errClear  in  1  clears errFlags next cycle (a new error in the same cycle wins)

Behaviour:
- Inputs registered once; falling edge = registered enable 1 -> 0. Nibble and rs taken from the last registered sample with enable high. enable-high width is counted in registered samples.
- Width < MIN_EN_HIGH: strobe ignored, errFlags[0] set.
- Reset values: byteValid 0, byteOut 0, byteIsData 0, cursorAddr 0, fourBitMode 0, twoLine 0, displayOn 0, entryIncrement 1, errFlags 0, nibble phase = high, busy 1. Reset runs a DDRAM clear.
- 8-bit mode (fourBitMode=0): each strobe is a byte {nibble, 4'h0}.
- 4-bit mode: the first strobe is the high nibble and the second is the low nibble. The byte uses the rs of the high strobe. An rs mismatch on the low strobe sets errFlags[1]; the byte still executes.
- byteValid pulses 2 cycles after the clk edge at which registered enable is first seen low, on the completing strobe.
- Command decode, priority on highest set bit:
  - 0x01 clear: fill DDRAM with 0x20, cursorAddr 0, entryIncrement 1.
  - 0x02-0x03: cursorAddr 0.
  - 0x04-0x07: entryIncrement = b1.
  - 0x08-0x0F: displayOn = b2.
  - 0x10-0x1F: if b3=0, move cursor (b2=1 right, else left) with the wrap rules below; if b3=1 (display shift), ignore.
  - 0x20-0x3F: fourBitMode = ~b4, twoLine = b3. A switch to 4-bit resets the nibble phase to high. In 4-bit mode, b4=1 returns to 8-bit.
  - 0x40-0x7F (CGRAM): ignored.
  - 0x80+: cursorAddr = b[6:0].
- Data byte: write DDRAM[cursorAddr], then step cursorAddr.
- Valid addresses are 0x00..LINE_LEN-1 and 0x40..0x40+LINE_LEN-1.
- Increment wrap: LINE_LEN-1 -> 0x40, 0x40+LINE_LEN-1 -> 0x00. Decrement wrap: 0x00 -> 0x40+LINE_LEN-1, 0x40 -> LINE_LEN-1.
- Data write at an invalid address: no write, no step, errFlags[2] set.
- Clear: busy high for 2*LINE_LEN cycles, one location per cycle. A completed strobe while busy is dropped, nibble phase unchanged, errFlags[3] set.
- rdData is registered, 1-cycle latency. An invalid rdAddr returns 0x00. A same-cycle write and read of one address returns the old data.
- rst_n low mid-byte discards a pending high nibble and restarts the clear.

Test Plan:
- Reset, then 0x3,0x3,0x3,0x2 upper-nibble strobes -> fourBitMode=1 after the fourth; busy falls 80 cycles after reset; rdData(any valid address)=0x20.
- 4-bit 0x28, 0x0C, 0x06, 0x01 -> twoLine=1, displayOn=1, entryIncrement=1, cursorAddr=0, 4 byteValid pulses with byteIsData=0.
- 4-bit data "H"(0x48) at 0x80|0x27 -> DDRAM[0x27]=0x48, cursorAddr=0x40; decrement mode at 0x00 -> cursorAddr=0x67.
- Strobe 3 cycles high with MIN_EN_HIGH=4 -> no byteValid, errFlags=0001; errClear -> 0000.
- High nibble rs=1, low nibble rs=0 -> byte executed as data, errFlags[1]=1; set address 0x30 then data -> no write, errFlags[2]=1.
- 0x01 then an immediate strobe pair -> errFlags[3]=1, cursorAddr stays 0; rst_n pulsed after one nibble -> next two nibbles assemble a correct byte.

Source files
------------

// File: rtl/lcd_bus_responder_if.sv
// 4-bit HD44780 LCD bus: data nibble, register select and enable strobe.
`timescale 1ns/1ps
interface lcd_bus_responder_if;
    logic db4;
    logic db5;
    logic db6;
    logic db7;
    logic rs;
    logic enable;

    modport master (output db4, db5, db6, db7, rs, enable);
    modport slave  (input  db4, db5, db6, db7, rs, enable);
endinterface

// File: rtl/lcd_bus_responder.sv
// HD44780-compatible responder: decodes enable strobes into bytes, executes the
// controller's command subset and keeps a 2-line DDRAM image with a read port.
`timescale 1ns/1ps
module lcd_bus_responder #(
    parameter int unsigned MIN_EN_HIGH = 4,
    parameter int unsigned LINE_LEN    = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lcd_bus_responder_if.slave   bus,
    input  logic [6:0]           rdAddr,
    output logic [7:0]           rdData,
    output logic                 byteValid,
    output logic [7:0]           byteOut,
    output logic                 byteIsData,
    output logic [6:0]           cursorAddr,
    output logic                 fourBitMode,
    output logic                 twoLine,
    output logic                 displayOn,
    output logic                 entryIncrement,
    output logic                 busy,
    output logic [3:0]           errFlags,
    input  logic                 errClear
);

    localparam int unsigned DEPTH = 2 * LINE_LEN;
    localparam int unsigned IW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(MIN_EN_HIGH + 1);
    localparam logic [6:0]  L0_LAST  = 7'(LINE_LEN - 1);
    localparam logic [6:0]  L1_FIRST = 7'h40;
    localparam logic [6:0]  L1_LAST  = 7'(32'h40 + LINE_LEN - 1);
    localparam logic [IW-1:0] CLR_LAST = IW'(DEPTH - 1);

    typedef enum logic [0:0] {ST_RUN, ST_CLEAR} state_t;
    state_t state, state_n;

    function automatic logic addr_ok(input logic [6:0] a);
        return 32'(a[5:0]) < LINE_LEN;
    endfunction

    // DDRAM is stored compacted: line 0 then line 1, no holes.
    function automatic logic [IW-1:0] mem_idx(input logic [6:0] a);
        int unsigned i;
        i = a[6] ? LINE_LEN + 32'(a[5:0]) : 32'(a[5:0]);
        return IW'(i);
    endfunction

    function automatic logic [6:0] step(input logic [6:0] a, input logic up);
        if (up) begin
            if (a == L0_LAST) return L1_FIRST;
            if (a == L1_LAST) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00)    return L1_LAST;
        if (a == L1_FIRST) return L0_LAST;
        return a - 7'd1;
    endfunction

    logic          en_q, en_d, rs_q, rs_last;
    logic [3:0]    nib_q, nib_last;
    logic [CW-1:0] hi_cnt;
    logic          strb_v, strb_short, strb_rs;
    logic [3:0]    strb_nib;

    // Input sampling, falling-edge detect and enable-high width count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            en_d       <= 1'b0;
            rs_q       <= 1'b0;
            nib_q      <= '0;
            rs_last    <= 1'b0;
            nib_last   <= '0;
            hi_cnt     <= '0;
            strb_v     <= 1'b0;
            strb_short <= 1'b0;
            strb_rs    <= 1'b0;
            strb_nib   <= '0;
        end else begin
            en_q  <= bus.enable;
            rs_q  <= bus.rs;
            nib_q <= {bus.db7, bus.db6, bus.db5, bus.db4};
            en_d  <= en_q;
            if (en_q) begin
                rs_last  <= rs_q;
                nib_last <= nib_q;
                if (hi_cnt != CW'(MIN_EN_HIGH))
                    hi_cnt <= hi_cnt + 1'b1;
            end else begin
                hi_cnt <= '0;
            end
            strb_v     <= en_d & ~en_q;
            strb_short <= hi_cnt < CW'(MIN_EN_HIGH);
            strb_rs    <= rs_last;
            strb_nib   <= nib_last;
        end
    end

    logic          phase_lo, phase_lo_n, hi_rs, hi_rs_n;
    logic [3:0]    hi_nib, hi_nib_n;
    logic          byte_go, byte_rs, start_clear;
    logic [7:0]    byte_val;
    logic [3:0]    err_new, err_n;
    logic [6:0]    cursor_n;
    logic          four_n, two_n, disp_n, inc_n;
    logic          wr_en;
    logic [IW-1:0] wr_idx, clr_idx;
    logic [7:0]    wr_data;

    always_comb begin
        phase_lo_n  = phase_lo;
        hi_nib_n    = hi_nib;
        hi_rs_n     = hi_rs;
        byte_go     = 1'b0;
        byte_val    = '0;
        byte_rs     = 1'b0;
        err_new     = '0;
        cursor_n    = cursorAddr;
        four_n      = fourBitMode;
        two_n       = twoLine;
        disp_n      = displayOn;
        inc_n       = entryIncrement;
        start_clear = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = '0;
        wr_data     = '0;

        if (strb_v) begin
            if (strb_short) begin
                err_new[0] = 1'b1;
            end else if (busy) begin
                err_new[3] = 1'b1;
            end else if (!fourBitMode) begin
                byte_go  = 1'b1;
                byte_val = {strb_nib, 4'h0};
                byte_rs  = strb_rs;
            end else if (!phase_lo) begin
                hi_nib_n   = strb_nib;
                hi_rs_n    = strb_rs;
                phase_lo_n = 1'b1;
            end else begin
                byte_go    = 1'b1;
                byte_val   = {hi_nib, strb_nib};
                byte_rs    = hi_rs;
                phase_lo_n = 1'b0;
                err_new[1] = strb_rs != hi_rs;
            end
        end

        if (byte_go) begin
            if (byte_rs) begin
                if (addr_ok(cursorAddr)) begin
                    wr_en    = 1'b1;
                    wr_idx   = mem_idx(cursorAddr);
                    wr_data  = byte_val;
                    cursor_n = step(cursorAddr, entryIncrement);
                end else begin
                    err_new[2] = 1'b1;
                end
            end else if (byte_val[7]) begin
                cursor_n = byte_val[6:0];
            end else if (byte_val[6]) begin
                // CGRAM address: no CGRAM modelled
            end else if (byte_val[5]) begin
                four_n = ~byte_val[4];
                two_n  = byte_val[3];
                if (!byte_val[4]) phase_lo_n = 1'b0;
            end else if (byte_val[4]) begin
                if (!byte_val[3]) cursor_n = step(cursorAddr, byte_val[2]);
            end else if (byte_val[3]) begin
                disp_n = byte_val[2];
            end else if (byte_val[2]) begin
                inc_n = byte_val[1];
            end else if (byte_val[1]) begin
                cursor_n = '0;
            end else if (byte_val[0]) begin
                cursor_n    = '0;
                inc_n       = 1'b1;
                start_clear = 1'b1;
            end
        end

        err_n = (errClear ? 4'h0 : errFlags) | err_new;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_CLEAR: if (clr_idx == CLR_LAST) state_n = ST_RUN;
            ST_RUN:   if (start_clear) state_n = ST_CLEAR;
            default:  state_n = ST_CLEAR;
        endcase
    end

    assign busy = (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_CLEAR;
            clr_idx        <= '0;
            phase_lo       <= 1'b0;
            hi_nib         <= '0;
            hi_rs          <= 1'b0;
            byteValid      <= 1'b0;
            byteOut        <= '0;
            byteIsData     <= 1'b0;
            cursorAddr     <= '0;
            fourBitMode    <= 1'b0;
            twoLine        <= 1'b0;
            displayOn      <= 1'b0;
            entryIncrement <= 1'b1;
            errFlags       <= '0;
        end else begin
            state          <= state_n;
            clr_idx        <= (busy && clr_idx != CLR_LAST) ? clr_idx + 1'b1 : '0;
            phase_lo       <= phase_lo_n;
            hi_nib         <= hi_nib_n;
            hi_rs          <= hi_rs_n;
            byteValid      <= byte_go;
            if (byte_go) begin
                byteOut    <= byte_val;
                byteIsData <= byte_rs;
            end
            cursorAddr     <= cursor_n;
            fourBitMode    <= four_n;
            twoLine        <= two_n;
            displayOn      <= disp_n;
            entryIncrement <= inc_n;
            errFlags       <= err_n;
        end
    end

    logic [7:0] mem [DEPTH];

    // Strobes are dropped while clearing, so the two writers never collide
    always_ff @(posedge clk) begin
        if (busy)
            mem[clr_idx] <= 8'h20;
        else if (wr_en)
            mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rdData <= '0;
        else if (addr_ok(rdAddr))
            rdData <= mem[mem_idx(rdAddr)];
        else
            rdData <= '0;
    end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed self-checking bench for lcd_bus_responder (MIN_EN_HIGH=4, LINE_LEN=40).
`timescale 1ns/1ps
module tb_lcd_bus_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] rdAddr;
    logic [7:0] rdData;
    logic       byteValid;
    logic [7:0] byteOut;
    logic       byteIsData;
    logic [6:0] cursorAddr;
    logic       fourBitMode, twoLine, displayOn, entryIncrement, busy;
    logic [3:0] errFlags;
    logic       errClear;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned bv_cnt  = 0;
    logic [7:0]  last_byte = '0;
    logic        last_isdata = 1'b0;

    always #5 clk = ~clk;

    lcd_bus_responder_if bus();

    lcd_bus_responder #(.MIN_EN_HIGH(4), .LINE_LEN(40)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .rdAddr(rdAddr), .rdData(rdData),
        .byteValid(byteValid), .byteOut(byteOut), .byteIsData(byteIsData),
        .cursorAddr(cursorAddr), .fourBitMode(fourBitMode), .twoLine(twoLine),
        .displayOn(displayOn), .entryIncrement(entryIncrement), .busy(busy),
        .errFlags(errFlags), .errClear(errClear)
    );

    always @(negedge clk) begin
        if (byteValid) begin
            bv_cnt++;
            last_byte   = byteOut;
            last_isdata = byteIsData;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [3:0] nib, input logic r, input int unsigned width);
        @(negedge clk);
        {bus.db7, bus.db6, bus.db5, bus.db4} = nib;
        bus.rs     = r;
        bus.enable = 1'b1;
        repeat (width) @(negedge clk);
        bus.enable = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic r);
        strobe(b[7:4], r, 4);
        strobe(b[3:0], r, 4);
    endtask

    task automatic read_check(input string tag, input logic [6:0] a, input logic [7:0] exp);
        @(negedge clk);
        rdAddr = a;
        @(negedge clk);
        check(tag, 32'(rdData), 32'(exp));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check("idle", 32'(busy), 32'd0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        errClear = 1'b1;
        @(negedge clk);
        errClear = 1'b0;
        check("err_cleared", 32'(errFlags), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int unsigned bv0;

    initial begin
        rst_n = 1'b0;
        errClear = 1'b0;
        rdAddr = '0;
        {bus.db7, bus.db6, bus.db5, bus.db4} = 4'h0;
        bus.rs = 1'b0;
        bus.enable = 1'b0;

        do_reset();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_modes", 32'({fourBitMode, twoLine, displayOn, entryIncrement}), 32'b0001);
        check("rst_cursor", 32'(cursorAddr), 32'h0);
        check("rst_err", 32'(errFlags), 32'h0);
        check("rst_byte", 32'({byteValid, byteIsData, byteOut}), 32'h0);
        repeat (79) @(negedge clk);
        check("busy_79", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_80", 32'(busy), 32'd0);
        read_check("rd_clr_05", 7'h05, 8'h20);
        read_check("rd_clr_4f", 7'h4F, 8'h20);
        read_check("rd_invalid", 7'h28, 8'h00);

        // 8-bit init sequence ending in 4-bit mode
        strobe(4'h3, 1'b0, 4);
        strobe(4'h3, 1'b0, 4);
        strobe(4'h3, 1'b0, 4);
        check("still_8bit", 32'(fourBitMode), 32'd0);
        strobe(4'h2, 1'b0, 4);
        check("now_4bit", 32'(fourBitMode), 32'd1);
        check("init_bv", bv_cnt, 32'd4);
        check("init_last", 32'(last_byte), 32'h20);

        send_byte(8'h28, 1'b0);
        send_byte(8'h0C, 1'b0);
        send_byte(8'h06, 1'b0);
        send_byte(8'h01, 1'b0);
        check("cmd_bv", bv_cnt, 32'd8);
        check("cmd_isdata", 32'(last_isdata), 32'd0);
        check("clear_busy", 32'(busy), 32'd1);
        wait_idle();
        check("cmd_modes", 32'({fourBitMode, twoLine, displayOn, entryIncrement}), 32'b1111);
        check("cmd_cursor", 32'(cursorAddr), 32'h0);

        send_byte(8'hA7, 1'b0);
        send_byte(8'h48, 1'b1);
        check("wrap_inc", 32'(cursorAddr), 32'h40);
        check("data_isdata", 32'(last_isdata), 32'd1);
        read_check("rd_27", 7'h27, 8'h48);

        send_byte(8'h04, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h41, 1'b1);
        check("wrap_dec", 32'(cursorAddr), 32'h67);
        read_check("rd_00", 7'h00, 8'h41);
        send_byte(8'h14, 1'b0);
        check("shift_right", 32'(cursorAddr), 32'h00);
        send_byte(8'h10, 1'b0);
        check("shift_left", 32'(cursorAddr), 32'h67);
        send_byte(8'h1C, 1'b0);
        check("disp_shift", 32'(cursorAddr), 32'h67);

        bv0 = bv_cnt;
        strobe(4'h0, 1'b0, 3);
        check("short_err", 32'(errFlags), 32'b0001);
        check("short_nobv", bv_cnt, bv0);
        pulse_clear();

        send_byte(8'h06, 1'b0);
        strobe(4'h4, 1'b1, 4);
        strobe(4'h2, 1'b0, 4);
        check("rs_err", 32'(errFlags), 32'b0010);
        check("rs_byte", 32'({last_isdata, last_byte}), 32'h142);
        check("rs_cursor", 32'(cursorAddr), 32'h00);
        read_check("rd_67", 7'h67, 8'h42);
        pulse_clear();

        send_byte(8'hB0, 1'b0);
        send_byte(8'h55, 1'b1);
        check("addr_err", 32'(errFlags), 32'b0100);
        check("addr_nostep", 32'(cursorAddr), 32'h30);
        read_check("rd_30", 7'h30, 8'h00);
        pulse_clear();

        send_byte(8'h01, 1'b0);
        bv0 = bv_cnt;
        send_byte(8'h85, 1'b0);
        check("busy_err", 32'(errFlags), 32'b1000);
        check("busy_cursor", 32'(cursorAddr), 32'h00);
        check("busy_nobv", bv_cnt, bv0);
        wait_idle();
        send_byte(8'h85, 1'b0);
        check("phase_kept", 32'(cursorAddr), 32'h05);
        read_check("rd_27_clr", 7'h27, 8'h20);

        strobe(4'hF, 1'b1, 4);
        do_reset();
        wait_idle();
        check("rst2_4bit", 32'(fourBitMode), 32'd0);
        strobe(4'h2, 1'b0, 4);
        send_byte(8'h8A, 1'b0);
        check("rst2_byte", 32'(last_byte), 32'h8A);
        check("rst2_cursor", 32'(cursorAddr), 32'h0A);
        check("rst2_err", 32'(errFlags), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1);
    end

endmodule
